// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
`include "width_param.sv"

package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } if_state_e;

  localparam logic [`ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [`ADDR_WIDTH-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`INST_WIDTH-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// Output register toward decode plus a one-entry skid buffer; flush empties both.
`include "width_param.sv"

module if_skid_buf
  import if_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [`ADDR_WIDTH-1:0] in_pc,
  input  logic [`INST_WIDTH-1:0] in_inst,
  input  logic                   out_ready,
  output logic                   slot_free,
  output logic                   out_valid,
  output logic [`ADDR_WIDTH-1:0] out_pc,
  output logic [`INST_WIDTH-1:0] out_inst
);

  if_entry_t out_q, out_d;
  if_entry_t buf_q, buf_d;
  logic      out_valid_q, out_valid_d;
  logic      buf_valid_q, buf_valid_d;
  if_entry_t in_entry;

  assign in_entry  = '{pc: in_pc, inst: in_inst};
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    out_d       = out_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    buf_valid_d = buf_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // The buffer always drains ahead of new data so ordering is preserved.
      if (buf_valid_q && out_ready) begin
        out_d       = buf_q;
        out_valid_d = 1'b1;
        buf_valid_d = 1'b0;
      end else if (in_valid) begin
        if (slot_free) begin
          out_d       = in_entry;
          out_valid_d = 1'b1;
        end else begin
          buf_d       = in_entry;
          buf_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;

endmodule

// File: rtl/width_param.sv
// Global datapath widths shared by the fetch stage and its neighbours.
`ifndef WIDTH_PARAM_SV
`define WIDTH_PARAM_SV
`define ADDR_WIDTH 32
`define INST_WIDTH 32
`endif

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, runs the single-outstanding instruction bus
// handshake and hands {pc, inst} to decode through if_skid_buf.
`include "width_param.sv"

module inst_fetch
  import if_pkg::*;
#(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   inst_req,
  output logic [`ADDR_WIDTH-1:0] inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [`INST_WIDTH-1:0] inst_rdata,
  input  logic                   redirect_en,
  input  logic [`ADDR_WIDTH-1:0] redirect_addr,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [`ADDR_WIDTH-1:0] if_pc,
  output logic [`INST_WIDTH-1:0] if_inst
);

  if_state_e              state_q;
  logic [`ADDR_WIDTH-1:0] fetch_pc_q;
  logic [`ADDR_WIDTH-1:0] req_pc_q;
  logic                   drop_q;
  logic                   slot_free;
  logic                   resp_valid;

  // A response is delivered downstream only if it is neither stale nor
  // overtaken by a redirect arriving in the same cycle.
  assign resp_valid = (state_q == WAIT) && inst_data_ok && !drop_q && !redirect_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc_q <= redirect_addr;
      case (state_q)
        WAIT: begin
          if (inst_data_ok) begin
            drop_q  <= 1'b0;
            state_q <= REQ;
          end else begin
            drop_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        REQ: begin
          if (inst_addr_ok) begin
            drop_q  <= 1'b1;
            state_q <= WAIT;
          end else begin
            state_q <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (inst_addr_ok) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else if (slot_free) begin
              state_q <= REQ;
            end else begin
              state_q <= FULL;
            end
          end
        end
        FULL: begin
          if (id_ready) begin
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_req  = (state_q == REQ);
  assign inst_addr = fetch_pc_q;

  if_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_en),
    .in_valid  (resp_valid),
    .in_pc     (req_pc_q),
    .in_inst   (inst_rdata),
    .out_ready (id_ready),
    .slot_free (slot_free),
    .out_valid (if_valid),
    .out_pc    (if_pc),
    .out_inst  (if_inst)
  );

endmodule
